// File: rtl/fpu_mantissa_mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpu_mantissa_mul_arbiter_pkg
//   Shared constants for the mantissa multiplier arbiter and its pipeline.
//   FPU_MAN_W / FPU_PROD_W describe the default bfloat16 configuration
//   (stored mantissa of 7 bits). The helper functions give the same widths
//   for any mantissa width so parameterised modules stay consistent.
//   REQ_FMADD / REQ_FMUL are the requester IDs returned on rsp_id.
// ---------------------------------------------------------------------------
package fpu_mantissa_mul_arbiter_pkg;

  localparam int FPU_MAN_DEF = 7;
  // Operand: hidden bit + stored mantissa + guard bit.
  localparam int FPU_MAN_W   = FPU_MAN_DEF + 2;
  // Full unsigned product of two operands, never truncated.
  localparam int FPU_PROD_W  = 2 * FPU_MAN_DEF + 4;

  localparam logic REQ_FMADD = 1'b0;
  localparam logic REQ_FMUL  = 1'b1;

  function automatic int man_w(input int man);
    return man + 2;
  endfunction

  function automatic int prod_w(input int man);
    return 2 * man + 4;
  endfunction

endpackage

// File: rtl/fpu_mmul_pipe.sv
// ---------------------------------------------------------------------------
// fpu_mmul_pipe
//   LAT-deep shift register carrying valid/id/tag/product, with the shared
//   mantissa multiplier sitting on the stage-0 operands. All stages move
//   together when i_adv is high and hold otherwise.
//
//   Ports
//     clk, rst_l        clock, asynchronous active-low reset
//     i_adv             shift enable for every stage
//     i_vld             an accepted request enters stage 0 on this advance
//     i_id, i_tag       requester ID and tag of the accepted request
//     i_a, i_b          operands of the accepted request (MAN+2 bits)
//     o_vld             last-stage valid (product presented)
//     o_busy            any stage holds a valid entry
//     o_id, o_tag       ID / tag of the presented product, 0 when !o_vld
//     o_prod            unsigned product (2*MAN+4 bits), 0 when !o_vld
// ---------------------------------------------------------------------------
module fpu_mmul_pipe
  import fpu_mantissa_mul_arbiter_pkg::*;
#(
  parameter int MAN   = FPU_MAN_DEF,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               i_adv,
  input  logic               i_vld,
  input  logic               i_id,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [MAN+1:0]     i_a,
  input  logic [MAN+1:0]     i_b,
  output logic               o_vld,
  output logic               o_busy,
  output logic               o_id,
  output logic [TAG_W-1:0]   o_tag,
  output logic [2*MAN+3:0]   o_prod
);

  localparam int MW = man_w(MAN);
  localparam int PW = prod_w(MAN);

  logic [LAT-1:0]   r_vld;
  logic [LAT-1:0]   r_id;
  logic [TAG_W-1:0] r_tag [LAT];
  logic [MW-1:0]    r_a;
  logic [MW-1:0]    r_b;

  logic             w_act;
  logic [PW-1:0]    w_mul;
  logic [PW-1:0]    w_prod [LAT];

  // Control shift register. ID/tag of stage 0 only load on an issued
  // operation; bubbles carry stale ID/tag that the output gating hides.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_vld <= '0;
      r_id  <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else if (i_adv) begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_id[0]  <= i_id;
        r_tag[0] <= i_tag;
      end
    end
  end

  // Operand registers change only when an operation is issued, so the
  // multiplier inputs stay quiet during idle and bubble cycles.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_adv && i_vld) begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  // Multiplier activation follows the stage-0 valid bit.
  assign w_act     = r_vld[0];
  assign w_mul     = w_act ? (PW'(r_a) * PW'(r_b)) : '0;
  assign w_prod[0] = w_mul;

  // Product registers for stages 1..LAT-1 (none when LAT == 1).
  for (genvar s = 1; s < LAT; s++) begin : g_stage
    logic [PW-1:0] r_prod;
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)     r_prod <= '0;
      else if (i_adv) r_prod <= w_prod[s-1];
    end
    assign w_prod[s] = r_prod;
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_busy = |r_vld;
  assign o_id   = o_vld & r_id[LAT-1];
  assign o_tag  = o_vld ? r_tag[LAT-1]  : '0;
  assign o_prod = o_vld ? w_prod[LAT-1] : '0;

endmodule

// File: rtl/fpu_mantissa_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_mantissa_mul_arbiter
//   Shares one pipelined mantissa multiplier between the FMADD path
//   (requester 0) and the FMUL/convert path (requester 1) with round-robin
//   arbitration. Products return in acceptance order with requester ID and
//   tag on a single backpressured result channel.
//
//   Ports
//     clk, rst_l              clock, asynchronous active-low reset
//     req_valid[1:0]          request valid, bit i = requester i
//     req_ready[1:0]          request accept, at most one bit set
//     req0_a/b, req1_a/b      operands (MAN+2 bits)
//     req0_tag, req1_tag      opaque tags (TAG_W bits)
//     rsp_valid / rsp_ready   result handshake
//     rsp_id, rsp_tag         issuing requester and its tag
//     rsp_product             full unsigned A*B (2*MAN+4 bits)
//     busy                    any pipeline stage holds a valid entry
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   req_ready is combinational from req_valid, rsp_ready and the output
//   stage; requesters must not make req_valid depend on req_ready. Once
//   rsp_valid is high the product, ID and tag hold until rsp_ready.
//   A requester may drop req_valid without being accepted.
// ---------------------------------------------------------------------------
module fpu_mantissa_mul_arbiter
  import fpu_mantissa_mul_arbiter_pkg::*;
#(
  parameter int MAN   = FPU_MAN_DEF,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [MAN+1:0]     req0_a,
  input  logic [MAN+1:0]     req0_b,
  input  logic [MAN+1:0]     req1_a,
  input  logic [MAN+1:0]     req1_b,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [2*MAN+3:0]   rsp_product,
  output logic               busy
);

  // Round-robin pointer: the requester that wins when both are valid.
  logic               r_ptr;
  logic               w_adv;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_win;
  logic [MAN+1:0]     w_a;
  logic [MAN+1:0]     w_b;
  logic [TAG_W-1:0]   w_tag;

  always_comb begin
    w_grant = req_valid;
    if (req_valid == 2'b11) begin
      w_grant = (r_ptr == REQ_FMUL) ? 2'b10 : 2'b01;
    end
  end

  // The whole pipe moves unless a product sits unaccepted at the output.
  assign w_adv     = !rsp_valid || rsp_ready;
  // No grants while reset is asserted.
  assign req_ready = (rst_l && w_adv) ? w_grant : 2'b00;
  assign w_accept  = |(req_valid & req_ready);
  assign w_win     = req_ready[1];

  assign w_a   = w_win ? req1_a   : req0_a;
  assign w_b   = w_win ? req1_b   : req0_b;
  assign w_tag = w_win ? req1_tag : req0_tag;

  // After an acceptance the other requester gets priority.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)        r_ptr <= REQ_FMADD;
    else if (w_accept) r_ptr <= ~w_win;
  end

  fpu_mmul_pipe #(
    .MAN   (MAN),
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_pipe (
    .clk    (clk),
    .rst_l  (rst_l),
    .i_adv  (w_adv),
    .i_vld  (w_accept),
    .i_id   (w_win),
    .i_tag  (w_tag),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_vld  (rsp_valid),
    .o_busy (busy),
    .o_id   (rsp_id),
    .o_tag  (rsp_tag),
    .o_prod (rsp_product)
  );

endmodule

// File: tb/tb_fpu_mantissa_mul_arbiter.sv
module tb_fpu_mantissa_mul_arbiter;

  localparam int MAN   = 7;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;
  localparam int MW    = MAN + 2;
  localparam int PW    = 2 * MAN + 4;
  localparam int EW    = 1 + TAG_W + PW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [MW-1:0]    req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [PW-1:0]    rsp_product;
  logic             busy;

  fpu_mantissa_mul_arbiter #(.MAN(MAN), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req0_tag    (req0_tag),
    .req1_tag    (req1_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_tag     (rsp_tag),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot is one cycle of latency; the last slot is what the consumer sees.
  typedef struct packed {
    logic             v;
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    prod;
  } ent_t;

  ent_t m_st [LAT];
  logic m_ptr;

  function automatic logic m_adv();
    return !m_st[LAT-1].v || rsp_ready;
  endfunction

  function automatic logic [1:0] m_ready();
    if (!rst_l || !m_adv()) return 2'b00;
    if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < LAT; i++) m_st[i] <= '0;
      m_ptr <= 1'b0;
    end else begin : upd
      logic [1:0]    acc;
      ent_t          e;
      logic [PW-1:0] pa;
      logic [PW-1:0] pb;
      acc = req_valid & m_ready();
      e   = '0;
      if (acc != 2'b00) begin
        e.v   = 1'b1;
        e.id  = acc[1];
        e.tag = acc[1] ? req1_tag : req0_tag;
        pa    = acc[1] ? PW'(req1_a) : PW'(req0_a);
        pb    = acc[1] ? PW'(req1_b) : PW'(req0_b);
        e.prod = pa * pb;
        m_ptr <= ~acc[1];
      end
      if (m_adv()) begin
        for (int i = LAT - 1; i > 0; i--) m_st[i] <= m_st[i-1];
        m_st[0] <= e;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  always @(negedge clk) begin : cmp
    ent_t t;
    logic exp_busy;
    t = m_st[LAT-1];
    exp_busy = 1'b0;
    for (int i = 0; i < LAT; i++) exp_busy = exp_busy | m_st[i].v;
    check("cyc_req_ready",   32'(req_ready),   32'(m_ready()));
    check("cyc_rsp_valid",   32'(rsp_valid),   32'(t.v));
    check("cyc_rsp_id",      32'(rsp_id),      t.v ? 32'(t.id)   : 32'd0);
    check("cyc_rsp_tag",     32'(rsp_tag),     t.v ? 32'(t.tag)  : 32'd0);
    check("cyc_rsp_product", 32'(rsp_product), t.v ? 32'(t.prod) : 32'd0);
    check("cyc_busy",        32'(busy),        32'(exp_busy));
    if (rst_l && rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_tag, rsp_product});
  end

  task automatic check_log(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_entry"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [TAG_W-1:0] t);
    req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic set_req1(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [TAG_W-1:0] t);
    req1_a = a; req1_b = b; req1_tag = t;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    rst_l = 1'b0; rsp_ready = 1'b1; req_valid = 2'b00;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst_l = 1'b1;

    // idle
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_rsp_valid", 32'(rsp_valid), 0);
      check("idle_product", 32'(rsp_product), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_act", 32'(dut.u_pipe.w_act), 0);
    end

    // single request from requester 0
    set_req0(9'h080, 9'h080, 4'd3);
    req_valid = 2'b01;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("t1_busy", 32'(busy), 1);
    check("t1_early_valid", 32'(rsp_valid), 0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_product", 32'(rsp_product), 32'h4000);
    check("t1_id", 32'(rsp_id), 0);
    check("t1_tag", 32'(rsp_tag), 3);
    tick();
    check("t1_drained_valid", 32'(rsp_valid), 0);
    check("t1_drained_busy", 32'(busy), 0);

    // requester 1 back-to-back, tags 0..7
    got_q.delete(); exp_q.delete();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        set_req1(MW'(k + 1), 9'h100, TAG_W'(k));
        req_valid = 2'b10;
        exp_q.push_back({1'b1, TAG_W'(k), PW'((k + 1) * 256)});
        #1;
        check("b2b_ready", 32'(req_ready), 32'h2);
      end else begin
        req_valid = 2'b00;
      end
      tick();
      if (k >= 1) begin
        check("b2b_rsp_valid", 32'(rsp_valid), 1);
        check("b2b_tag", 32'(rsp_tag), 32'(k - 1));
      end
    end
    tick(); tick();
    check_log("b2b");

    // two entries in flight, then asynchronous reset
    set_req0(9'h011, 9'h022, 4'd1);
    req_valid = 2'b01;
    tick();
    set_req1(9'h033, 9'h044, 4'd2);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00; rsp_ready = 1'b0;
    check("mid_busy", 32'(busy), 1);
    check("mid_rsp_valid", 32'(rsp_valid), 1);
    #2;
    rst_l = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_product", 32'(rsp_product), 0);

    // simultaneous pair right after reset release: 0,1,0,1
    set_req0(9'h0FF, 9'h0FF, 4'hA);
    set_req1(9'h0C0, 9'h0A0, 4'hB);
    rsp_ready = 1'b1; req_valid = 2'b11;
    #1;
    check("arst_ready", 32'(req_ready), 0);
    got_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 4'hA, 18'h0FE01});
    exp_q.push_back({1'b1, 4'hB, 18'h07800});
    exp_q.push_back({1'b0, 4'hA, 18'h0FE01});
    exp_q.push_back({1'b1, 4'hB, 18'h07800});
    tick(); tick();
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    req_valid = 2'b00;
    tick(); tick(); tick();
    check_log("rr");

    // backpressure with all-ones operands
    got_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 4'd5, 18'h3FC01});
    exp_q.push_back({1'b1, 4'd6, 18'h0000F});
    set_req0(9'h1FF, 9'h1FF, 4'd5);
    set_req1(9'h003, 9'h005, 4'd6);
    rsp_ready = 1'b0; req_valid = 2'b11;
    #1;
    check("bp_fill0_ready", 32'(req_ready), 32'h1);
    tick();
    #1;
    check("bp_fill1_ready", 32'(req_ready), 32'h2);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 32'(req_ready), 0);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_product", 32'(rsp_product), 32'h3FC01);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_tag", 32'(rsp_tag), 5);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    tick();
    check("bp_second_product", 32'(rsp_product), 32'hF);
    check("bp_second_id", 32'(rsp_id), 1);
    check("bp_second_tag", 32'(rsp_tag), 6);
    tick(); tick();
    check_log("bp");
    check("end_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_mantissa_mul_arbiter.md
Name: fpu_mantissa_mul_arbiter

Overview:
- Shares one pipelined mantissa multiplier between two requesters: requester 0 is the FMADD path, requester 1 is the FMUL/convert path.
- Round-robin arbitration, valid/ready on both request ports, a single result channel with backpressure, and requester ID plus tag returned with each product.
- Sits between the FPU operation decoders and the mantissa product datapath. Gates multiplier activation so that the datapath toggles only on issued operations.

Parameters:
- MAN, 7, stored mantissa width. Operands are MAN+2 bits (hidden bit plus guard); the product is 2*MAN+4 bits. MAN=7 targets bfloat16.
- LAT, 2, pipeline depth in cycles from acceptance to rsp_valid. Legal range is 1..4.
- TAG_W, 4, width of the opaque tag carried with each request.

Ports:
- clk  input  1  core clock
- rst_l  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester request valid; bit i belongs to requester i
- req_ready  output  2  per-requester accept
- req0_a, req0_b  input  MAN+2  requester 0 operands
- req1_a, req1_b  input  MAN+2  requester 1 operands
- req0_tag, req1_tag  input  TAG_W  per-requester tags
- rsp_valid  output  1  product valid
- rsp_ready  input  1  consumer accepts product
- rsp_id  output  1  requester that issued the product
- rsp_tag  output  TAG_W  tag of the issuing request
- rsp_product  output  2*MAN+4  unsigned A*B
- busy  output  1  high while any pipeline stage holds a valid entry

Behaviour:
- Reset, asynchronous on rst_l low:
  - All stage valid bits clear.
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_product=0, busy=0, req_ready=0.
  - Round-robin pointer set so that requester 0 has priority.
- Reset mid-operation discards every in-flight product. Nothing is replayed.
- Advance condition: adv = !stage_valid[LAT-1] || rsp_ready. All LAT stages shift together on adv and hold on !adv. A bubble-collapse pipeline is not required.
- Arbitration, combinational each cycle:
  - Exactly one valid requester: that requester wins.
  - Both valid: the requester holding the round-robin pointer wins.
  - Neither valid: no grant.
- req_ready[i] = grant[i] && adv. At most one bit is set per cycle.
- req_ready may depend on req_valid and rsp_ready. req_valid must not depend on req_ready.
- Acceptance: req_valid[i] && req_ready[i] at a rising edge.
  - Operands, tag and id are captured into stage 0.
  - The round-robin pointer moves to the other requester.
  - With no acceptance the pointer is unchanged.
- Stage 0 is loaded with valid=0 on an adv cycle that has no acceptance.
- Multiply is performed on the stage-0 operands, and the activation input is stage_valid[0]. The product is carried through the remaining stages.
- Latency: a request accepted at edge N with no stall presents rsp_valid=1 after edge N+LAT-1 (LAT=2 means visible one cycle after the acceptance edge). Each stall cycle adds one.
- Throughput: one accepted request per cycle while rsp_ready=1.
- Output stage:
  - rsp_valid = stage_valid[LAT-1].
  - rsp_id, rsp_tag and rsp_product hold stable while rsp_valid && !rsp_ready.
  - rsp_product, rsp_id and rsp_tag are forced to 0 when rsp_valid=0.
- Arithmetic: full-width unsigned product with no truncation. All-ones operands give (2^(MAN+2)-1)^2.
- busy = OR of all stage valid bits.
- Simultaneous events:
  - A consumer pop and a new acceptance in the same cycle are both honoured.
  - A requester dropping req_valid without being accepted is legal and leaves no state.
- Ordering: products return strictly in acceptance order.

Decomposition:
- Shared package:
  - FPU_MAN_W localparam (MAN+2)
  - FPU_PROD_W localparam (2*MAN+4)
  - requester ID constants REQ_FMADD=0 and REQ_FMUL=1
- Sub-module fpu_mmul_pipe holds the gated multiplier plus the LAT-deep valid/id/tag/product shift register with a shared adv enable.
- Arbiter logic and the pointer stay in the top module.

Test Plan:
- Single request, LAT=2, MAN=7: req0 a=0x80, b=0x80, tag=3. Required: req_ready[0]=1 in the request cycle, then rsp_valid=1 after one more edge with rsp_product=0x4000, rsp_id=0, rsp_tag=3.
- Both requesters valid continuously for 4 cycles: req0 0xFF*0xFF, req1 0xC0*0xA0. Required: grants alternate 0,1,0,1 starting with requester 0. Products return in that order as 0xFE01, 0x7800, 0xFE01, 0x7800.
- Backpressure: fill the pipeline, then hold rsp_ready=0 for 3 cycles. Required: req_ready=0 throughout; rsp_product, rsp_id and rsp_tag stable. After release, every product emerges with none lost or duplicated.
- Back-to-back: requester 1 alone for 8 cycles with rsp_ready=1 and incrementing tags 0..7. Required: req_ready=1 every cycle and 8 consecutive rsp_valid cycles with tags 0..7.
- Reset mid-flight: assert rst_l=0 with two entries in flight. Required: rsp_valid=0 and busy=0 immediately (asynchronous). After release, a simultaneous request pair grants requester 0 first.
- Idle: no requests. Required: rsp_valid=0, rsp_product=0, busy=0, and stage 0 multiplier activation held low.
